// File: rtl/nmr_pkg.sv
// Shared definitions for the NMR acquisition packetizer: state codes,
// packet header magic and the default counter width.
package nmr_pkg;

    localparam int CNT_W_DEF = 32;

    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nmr_axis_fifo2.sv
// Two-entry registered FIFO carrying {data, last}. Slot 0 is always the head
// and drives the output directly. tail_last_set forces tlast on the youngest
// entry so an aborted run still closes its final packet.
module nmr_axis_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         tail_last_set,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] d0, d1;
    logic         l0, l1;
    logic [1:0]   cnt;
    logic         pop;

    assign pop       = (cnt != 2'd0) && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = d0;
    assign full      = (cnt == 2'd2);
    assign empty     = (cnt == 2'd0);
    // A lone head leaving in the abort cycle gets its tlast here, since
    // the register update would come one edge too late.
    assign out_last  = l0 | (tail_last_set && (cnt == 2'd1));

    // Shift-register FIFO: push fills the first free slot, pop shifts down.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
            cnt <= 2'd0;
        end else if (clear) begin
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    l0  <= l1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                end
                default: ;
            endcase
            // NOTE: non-blocking assignments to the same register take the
            // last one executed, so this override wins over the shift above.
            if (tail_last_set && !push) begin
                if (pop) begin
                    if (cnt == 2'd2) l0 <= 1'b1;
                end else begin
                    if (cnt == 2'd1) l0 <= 1'b1;
                    if (cnt == 2'd2) l1 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nmr_acq_packetizer.sv
// NMR acquisition packetizer: frames the dual-channel ADC stream into
// AXI4-Stream packets of cfg_size samples, stops after cfg_nb_samples and
// reports progress, overflow and abort to the sequencer FSM.
// Optional feature: define NMR_PCK_HEADER_EN to prefix every packet with a
// {16'hA5A5, packet_index} header word.
module nmr_acq_packetizer
    import nmr_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                clear,
    input  logic                enable,
    input  logic [CNT_W-1:0]    cfg_size,
    input  logic [CNT_W-1:0]    cfg_nb_samples,
    input  logic [2*DATA_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [CNT_W-1:0]    sts_count,
    output logic [1:0]          sts_state,
    output logic                done,
    output logic                overflow,
    output logic                aborted
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   size_q, nb_q, pkt_cnt_q, count_q;
    logic               overflow_q, aborted_q;

    logic               fifo_full, fifo_empty, pop, space;
    logic               run_en, accept, drop, push, push_last, tail_last_set;
    logic               pkt_end, final_smp, hdr_slot, hdr_push;
    logic [31:0]        push_data;

`ifdef NMR_PCK_HEADER_EN
    logic               hdr_q;
    logic [15:0]        pkt_idx_q;
    assign hdr_slot = run_en && hdr_q;
`else
    assign hdr_slot = 1'b0;
`endif

    assign pop       = m_axis_tvalid && m_axis_tready;
    assign space     = !fifo_full || pop;
    assign run_en    = (state_q == ST_RUN) && enable;
    assign pkt_end   = (pkt_cnt_q == size_q - ONE);
    assign final_smp = (count_q == nb_q - ONE);

    assign s_axis_tready = run_en && !hdr_slot;
    assign accept        = s_axis_tready && s_axis_tvalid && space;
    assign drop          = run_en && s_axis_tvalid && !space;
    assign hdr_push      = hdr_slot && space;
    assign push          = accept || hdr_push;
    assign tail_last_set = (state_q == ST_RUN) && !enable;

`ifdef NMR_PCK_HEADER_EN
    assign push_data = hdr_push ? {HDR_MAGIC, pkt_idx_q} : s_axis_tdata;
`else
    assign push_data = s_axis_tdata;
`endif
    assign push_last = !hdr_push && (pkt_end || final_smp);

    assign sts_count = count_q;
    assign sts_state = state_q;
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign aborted   = aborted_q;

    nmr_axis_fifo2 #(.W(32)) u_fifo (
        .clk           (clk),
        .aresetn       (aresetn),
        .clear         (clear),
        .push          (push),
        .push_data     (push_data),
        .push_last     (push_last),
        .tail_last_set (tail_last_set),
        .out_data      (m_axis_tdata),
        .out_valid     (m_axis_tvalid),
        .out_ready     (m_axis_tready),
        .out_last      (m_axis_tlast),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

    // State register; clear acts as a synchronous reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)   state_q <= ST_IDLE;
        else if (clear) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic for the acquisition sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable && (cfg_size != '0) && (cfg_nb_samples != '0))
                          state_d = ST_RUN;
            ST_RUN:   if (!enable)                   state_d = ST_FLUSH;
                      else if (accept && final_smp)  state_d = ST_FLUSH;
            ST_FLUSH: if (fifo_empty)                state_d = ST_DONE;
            ST_DONE:  if (!enable)                   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Config latch, sample/packet counters and sticky status flags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            size_q     <= '0;
            nb_q       <= '0;
            pkt_cnt_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef NMR_PCK_HEADER_EN
            hdr_q      <= 1'b0;
            pkt_idx_q  <= '0;
`endif
        end else if (clear) begin
            size_q     <= '0;
            nb_q       <= '0;
            pkt_cnt_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef NMR_PCK_HEADER_EN
            hdr_q      <= 1'b0;
            pkt_idx_q  <= '0;
`endif
        end else begin
            if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
                size_q    <= cfg_size;
                nb_q      <= cfg_nb_samples;
                pkt_cnt_q <= '0;
                count_q   <= '0;
`ifdef NMR_PCK_HEADER_EN
                hdr_q     <= 1'b1;
                pkt_idx_q <= '0;
`endif
            end
            if (accept) begin
                count_q   <= count_q + ONE;
                pkt_cnt_q <= pkt_end ? '0 : pkt_cnt_q + ONE;
`ifdef NMR_PCK_HEADER_EN
                hdr_q     <= pkt_end && !final_smp;
`endif
            end
`ifdef NMR_PCK_HEADER_EN
            if (hdr_push) begin
                hdr_q     <= 1'b0;
                pkt_idx_q <= pkt_idx_q + 16'd1;
            end
`endif
            if (drop)          overflow_q <= 1'b1;
            if (tail_last_set) aborted_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nmr_acq_packetizer.sv
// Directed testbench for nmr_acq_packetizer. Define NMR_PCK_HEADER_EN to
// exercise the header build instead of the plain-sample scenarios.
module tb_nmr_acq_packetizer;

    localparam logic [31:0] BASE = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] cfg_size = '0;
    logic [31:0] cfg_nb_samples = '0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] sts_count;
    logic [1:0]  sts_state;
    logic        done, overflow, aborted;

    int checks = 0;
    int failures = 0;

    logic [31:0] words[$];
    logic        lasts[$];
    int          first_valid;
    logic        stable_ok, saw_done;
    int          src_idx;

    always #5 clk = ~clk;

    nmr_acq_packetizer dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .clear          (clear),
        .enable         (enable),
        .cfg_size       (cfg_size),
        .cfg_nb_samples (cfg_nb_samples),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .sts_count      (sts_count),
        .sts_state      (sts_state),
        .done           (done),
        .overflow       (overflow),
        .aborted        (aborted)
    );

    // Drives a run with an always-valid source and records every output beat.
    // Cycle 0 is the first cycle enable is high. The downstream stalls for
    // cycles [stall_from, stall_to); enable drops once abort_after samples
    // have been handed over (0 = never). Stops at the first DONE cycle.
    task automatic run_capture(input int max_cycles, input int stall_from,
                               input int stall_to, input int abort_after);
        int          accepted;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        words.delete();
        lasts.delete();
        first_valid = -1;
        stable_ok   = 1'b1;
        saw_done    = 1'b0;
        src_idx     = 0;
        accepted    = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        for (int cyc = 0; cyc < max_cycles && !saw_done; cyc++) begin
            @(negedge clk);
            m_axis_tready = !(cyc >= stall_from && cyc < stall_to);
            enable        = !(abort_after > 0 && accepted >= abort_after);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = BASE + src_idx;
            #1;
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                               m_axis_tlast !== prev_last))
                stable_ok = 1'b0;
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                words.push_back(m_axis_tdata);
                lasts.push_back(m_axis_tlast);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tready && s_axis_tvalid) begin
                src_idx++;
                accepted++;
            end
            if (sts_state == 2'd3) saw_done = 1'b1;
        end
        checks++;
        if (!saw_done) begin
            failures++;
            $display("FAIL run_timeout: DONE not reached within %0d cycles, state=%0d",
                     max_cycles, sts_state);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({sts_state, m_axis_tvalid, m_axis_tlast, s_axis_tready, done,
             overflow, aborted} !== 8'b0 || sts_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: state=%0d tvalid=%b tlast=%b tready=%b done=%b ovf=%b abt=%b count=%0d, want all 0",
                     sts_state, m_axis_tvalid, m_axis_tlast, s_axis_tready, done,
                     overflow, aborted, sts_count);
        end
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        cfg_size = 32'd4;
        cfg_nb_samples = 32'd10;
        run_capture(60, -1, -1, 0);
        checks++;
        if (first_valid !== 2) begin
            failures++;
            $display("FAIL basic_latency: first tvalid at cycle %0d, want 2", first_valid);
        end
        checks++;
        if (words.size() !== 10) begin
            failures++;
            $display("FAIL basic_word_count: got %0d, want 10", words.size());
        end
        for (int i = 0; i < words.size() && i < 10; i++) begin
            checks++;
            if (words[i] !== BASE + i || lasts[i] !== (i == 3 || i == 7 || i == 9)) begin
                failures++;
                $display("FAIL basic_word[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, words[i], lasts[i], BASE + i, (i == 3 || i == 7 || i == 9));
            end
        end
        checks++;
        if (done !== 1'b1 || sts_count !== 32'd10 || overflow !== 1'b0 || aborted !== 1'b0) begin
            failures++;
            $display("FAIL basic_status: done=%b count=%0d ovf=%b abt=%b, want 1/10/0/0",
                     done, sts_count, overflow, aborted);
        end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sts_state !== 2'd0 || done !== 1'b0 || sts_count !== 32'd10) begin
            failures++;
            $display("FAIL basic_back_to_idle: state=%0d done=%b count=%0d, want 0/0/10",
                     sts_state, done, sts_count);
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        cfg_size = 32'd4;
        cfg_nb_samples = 32'd10;
        // Stall cycles 4..7: s3 fills the second slot, s4..s6 are dropped.
        run_capture(60, 4, 8, 0);
        checks++;
        if (words.size() !== 10) begin
            failures++;
            $display("FAIL ovf_word_count: got %0d, want 10", words.size());
        end
        for (int i = 0; i < words.size() && i < 10; i++) begin
            checks++;
            if (words[i] !== BASE + ((i < 4) ? i : i + 3) ||
                lasts[i] !== (i == 3 || i == 7 || i == 9)) begin
                failures++;
                $display("FAIL ovf_word[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, words[i], lasts[i], BASE + ((i < 4) ? i : i + 3),
                         (i == 3 || i == 7 || i == 9));
            end
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            failures++;
            $display("FAIL ovf_output_stable: output changed while stalled, stable=%b want 1", stable_ok);
        end
        checks++;
        if (overflow !== 1'b1 || sts_count !== 32'd10 || done !== 1'b1) begin
            failures++;
            $display("FAIL ovf_status: ovf=%b count=%0d done=%b, want 1/10/1",
                     overflow, sts_count, done);
        end
    endtask

    task automatic test_abort();
        pulse_clear();
        cfg_size = 32'd8;
        cfg_nb_samples = 32'd100;
        run_capture(80, -1, -1, 13);
        checks++;
        if (words.size() !== 13) begin
            failures++;
            $display("FAIL abort_word_count: got %0d, want 13", words.size());
        end
        for (int i = 0; i < words.size() && i < 13; i++) begin
            checks++;
            if (words[i] !== BASE + i || lasts[i] !== (i == 7 || i == 12)) begin
                failures++;
                $display("FAIL abort_word[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, words[i], lasts[i], BASE + i, (i == 7 || i == 12));
            end
        end
        checks++;
        if (aborted !== 1'b1 || overflow !== 1'b0 || sts_count !== 32'd13) begin
            failures++;
            $display("FAIL abort_status: abt=%b ovf=%b count=%0d, want 1/0/13",
                     aborted, overflow, sts_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sts_state !== 2'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_to_idle: state=%0d done=%b, want 0/0", sts_state, done);
        end
    endtask

    task automatic test_clear_mid_run();
        cfg_size = 32'd4;
        cfg_nb_samples = 32'd10;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            enable = 1'b1;
        end
        #1;
        checks++;
        if (sts_state !== 2'd1 || aborted !== 1'b1 || m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL clear_pre: state=%0d abt=%b tvalid=%b, want 1/1/1",
                     sts_state, aborted, m_axis_tvalid);
        end
        pulse_clear();
        s_axis_tvalid = 1'b0;
        #1;
        checks++;
        if ({sts_state, m_axis_tvalid, m_axis_tlast, s_axis_tready, done,
             overflow, aborted} !== 8'b0 || sts_count !== 32'd0 || m_axis_tdata !== 32'd0) begin
            failures++;
            $display("FAIL clear_outputs: state=%0d tvalid=%b tdata=%h tready=%b done=%b ovf=%b abt=%b count=%0d, want all 0",
                     sts_state, m_axis_tvalid, m_axis_tdata, s_axis_tready, done,
                     overflow, aborted, sts_count);
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_zero_config();
        logic bad;
        bad = 1'b0;
        cfg_size = 32'd0;
        cfg_nb_samples = 32'd5;
        repeat (3) begin
            @(negedge clk);
            enable = 1'b1;
            #1;
            if (sts_state !== 2'd0 || s_axis_tready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL zero_size: left IDLE, state=%0d tready=%b", sts_state, s_axis_tready);
        end
        bad = 1'b0;
        cfg_size = 32'd4;
        cfg_nb_samples = 32'd0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (sts_state !== 2'd0 || s_axis_tready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL zero_nb: left IDLE, state=%0d tready=%b", sts_state, s_axis_tready);
        end
        cfg_nb_samples = 32'd3;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sts_state !== 2'd1 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL nonzero_starts: state=%0d tready=%b, want 1/1", sts_state, s_axis_tready);
        end
        pulse_clear();
    endtask

`ifdef NMR_PCK_HEADER_EN
    task automatic test_header();
        logic [31:0] exp_w[8];
        logic        exp_l[8];
        exp_w = '{32'hA5A5_0000, BASE, BASE + 1, BASE + 2,
                  32'hA5A5_0001, BASE + 3, BASE + 4, BASE + 5};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        cfg_size = 32'd3;
        cfg_nb_samples = 32'd6;
        run_capture(60, -1, -1, 0);
        checks++;
        if (words.size() !== 8) begin
            failures++;
            $display("FAIL hdr_word_count: got %0d, want 8", words.size());
        end
        for (int i = 0; i < words.size() && i < 8; i++) begin
            checks++;
            if (words[i] !== exp_w[i] || lasts[i] !== exp_l[i]) begin
                failures++;
                $display("FAIL hdr_word[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, words[i], lasts[i], exp_w[i], exp_l[i]);
            end
        end
        checks++;
        if (sts_count !== 32'd6 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL hdr_status: count=%0d ovf=%b, want 6/0", sts_count, overflow);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef NMR_PCK_HEADER_EN
        test_header();
`else
        test_basic();
        test_overflow();
        test_abort();
        test_clear_mid_run();
        test_zero_config();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
